// File: rtl/da_dct_pkg.sv
// Shared definitions for the distributed-arithmetic 8-point DCT coefficient unit:
// point count, FSM state type, DCT coefficient function and partial-sum ROM function.
// The coefficient table below is exact enough for COEF_W in the range 5..25.
package da_dct_pkg;

   localparam int N = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // 0.5*cos(i*pi/16) scaled by 2^24, i = 0..8; every DCT coefficient is +/- one of these
   function automatic int half_cos_q24(input int i);
      int v;
      case (i)
         0:       v = 32'sd8388608;
         1:       v = 32'sd8227423;
         2:       v = 32'sd7750063;
         3:       v = 32'sd6974873;
         4:       v = 32'sd5931642;
         5:       v = 32'sd4660461;
         6:       v = 32'sd3210181;
         7:       v = 32'sd1636536;
         default: v = 32'sd0;
      endcase
      return v;
   endfunction

   // c(k,n) = round(C(k)/2 * cos((2n+1)k*pi/16) * 2^(coef_w-2))
   function automatic int c(input int k, input int n, input int coef_w);
      int m;
      int idx;
      int sh;
      int mag;
      logic neg;
      sh = 32'sd26 - coef_w;
      if (k == 32'sd0) begin
         // C(0)/2 = cos(pi/4)/2
         idx = 32'sd4;
         neg = 1'b0;
      end else begin
         m = ((32'sd2 * n + 32'sd1) * k) % 32'sd32;
         if (m <= 32'sd8) begin
            idx = m;
            neg = 1'b0;
         end else if (m <= 32'sd16) begin
            idx = 32'sd16 - m;
            neg = 1'b1;
         end else if (m <= 32'sd24) begin
            idx = m - 32'sd16;
            neg = 1'b1;
         end else begin
            idx = 32'sd32 - m;
            neg = 1'b0;
         end
      end
      mag = (half_cos_q24(idx) + (32'sd1 <<< (sh - 32'sd1))) >>> sh;
      return neg ? -mag : mag;
   endfunction

   // Partial sum of the four coefficients of one half selected by the address bits
   function automatic int lut(input int k, input int half, input logic [3:0] addr, input int coef_w);
      int sum;
      sum = 32'sd0;
      for (int b = 0; b < 4; b++) begin
         if (addr[b]) begin
            sum = sum + c(k, half * 32'sd4 + b, coef_w);
         end else begin
            sum = sum;
         end
      end
      return sum;
   endfunction

endpackage

// File: rtl/da_dct_coeff_if.sv
// Job/result handshake bundle for da_dct_coeff: samples and index in with
// start/in_ready, result out with out_valid/out_ready.
interface da_dct_coeff_if
   import da_dct_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int OUT_W  = DATA_W + 3
);
   logic [N-1:0][DATA_W-1:0] x;
   logic [2:0]               k;
   logic                     start;
   logic                     in_ready;
   logic signed [OUT_W-1:0]  y;
   logic                     out_valid;
   logic                     out_ready;

   modport master (output x, k, start, out_ready, input in_ready, y, out_valid);
   modport slave  (input x, k, start, out_ready, output in_ready, y, out_valid);
endinterface

// File: rtl/da_dct_lut.sv
// Combinational partial-sum ROM: one entry per 4-bit address, for one half
// (samples 0..3 or 4..7) of the coefficient row selected by k.
module da_dct_lut
   import da_dct_pkg::*;
#(
   parameter int COEF_W = 16
) (
   input  logic [2:0]              k,
   input  logic                    half,
   input  logic [3:0]              addr,
   output logic signed [COEF_W+1:0] entry
);
   localparam int EW = COEF_W + 2;

   // look up the sum of coefficients whose address bit is set
   always_comb begin
      entry = EW'(lut(int'(k), int'(half), addr, COEF_W));
   end
endmodule

// File: rtl/da_dct_coeff.sv
// Distributed-arithmetic DCT coefficient unit: Y = sum c[k][n]*x[n], one sample
// bit-plane per cycle, LSB first, sign plane subtracted.
// Optional macro DA_DCT_ROUND_EN: round half up instead of truncating the output.
module da_dct_coeff
   import da_dct_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int COEF_W = 16,
   parameter int OUT_W  = DATA_W + 3
) (
   input logic           clk,
   input logic           reset,
   da_dct_coeff_if.slave bus
);
   localparam int ACC_W = COEF_W + DATA_W + 3;
   localparam int CNT_W = $clog2(DATA_W);
   localparam int EW    = COEF_W + 2;
   localparam int SH    = COEF_W - 2;
   localparam logic [CNT_W-1:0]        LAST = CNT_W'(DATA_W - 1);
   localparam logic signed [ACC_W-1:0] RND  = ACC_W'(1) << (SH - 1);

   state_t                   state;
   logic [N-1:0][DATA_W-1:0] x_lat;
   logic [2:0]               k_lat;
   logic [CNT_W-1:0]         bit_cnt;
   logic signed [ACC_W-1:0]  acc;
   logic signed [OUT_W-1:0]  y_reg;
   logic                     valid_reg;
   logic                     ready;
   logic                     accept;
   logic [3:0]               addr_lo;
   logic [3:0]               addr_hi;
   logic signed [EW-1:0]     l_lo;
   logic signed [EW-1:0]     l_hi;
   logic signed [ACC_W-1:0]  plane_term;
   logic signed [ACC_W-1:0]  acc_next;
   logic signed [ACC_W-1:0]  y_full;

   assign ready         = (state == IDLE) | ((state == DONE) & bus.out_ready);
   assign accept        = ready & bus.start;
   assign bus.in_ready  = ready;
   assign bus.y         = y_reg;
   assign bus.out_valid = valid_reg;

   // gather the current bit-plane of each half into a ROM address
   always_comb begin
      addr_lo = 4'd0;
      addr_hi = 4'd0;
      for (int b = 0; b < 4; b++) begin
         addr_lo[b] = x_lat[b][bit_cnt];
         addr_hi[b] = x_lat[b+4][bit_cnt];
      end
   end

   da_dct_lut #(.COEF_W(COEF_W)) u_lut_lo (.k(k_lat), .half(1'b0), .addr(addr_lo), .entry(l_lo));
   da_dct_lut #(.COEF_W(COEF_W)) u_lut_hi (.k(k_lat), .half(1'b1), .addr(addr_hi), .entry(l_hi));

   // weight the plane sum by 2^j; the sign plane is subtracted
   always_comb begin
      plane_term = (ACC_W'(l_lo) + ACC_W'(l_hi)) <<< bit_cnt;
      if (bit_cnt == LAST) begin
         acc_next = acc - plane_term;
      end else begin
         acc_next = acc + plane_term;
      end
   end

   // rescale the finished sum to output units (floor, optionally half-up rounding)
   always_comb begin
`ifdef DA_DCT_ROUND_EN
      y_full = (acc_next + RND) >>> SH;
`else
      y_full = acc_next >>> SH;
`endif
   end

   // job FSM with accumulator, bit counter and registered result
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         acc       <= '0;
         bit_cnt   <= '0;
         x_lat     <= '0;
         k_lat     <= 3'd0;
         y_reg     <= '0;
         valid_reg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  x_lat   <= bus.x;
                  k_lat   <= bus.k;
                  acc     <= '0;
                  bit_cnt <= '0;
                  state   <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               acc <= acc_next;
               if (bit_cnt == LAST) begin
                  bit_cnt   <= '0;
                  y_reg     <= OUT_W'(y_full);
                  valid_reg <= 1'b1;
                  state     <= DONE;
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  valid_reg <= 1'b0;
                  if (bus.start) begin
                     x_lat   <= bus.x;
                     k_lat   <= bus.k;
                     acc     <= '0;
                     bit_cnt <= '0;
                     state   <= RUN;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  state <= DONE;
               end
            end
            default: begin
               state     <= IDLE;
               valid_reg <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_da_dct_coeff.sv
// Self-checking bench for da_dct_coeff: real-valued reference model feeding a
// scoreboard, directed corner cases, stall, reset-abort and random jobs.
module tb_da_dct_coeff;
   localparam int DW     = 8;
   localparam int CW     = 16;
   localparam int OW     = DW + 3;
   localparam int PERIOD = 10;
   localparam real PI    = 3.14159265358979323846;
`ifdef DA_DCT_ROUND_EN
   localparam longint EXP_ONES = 3;
   localparam longint EXP_NEG  = -362;
`else
   localparam longint EXP_ONES = 2;
   localparam longint EXP_NEG  = -363;
`endif

   logic clk;
   logic reset;
   int   total;
   int   bad;
   longint sb[$];
   longint accept_time;

   da_dct_coeff_if #(.DATA_W(DW), .OUT_W(OW)) bus ();

   da_dct_coeff #(.DATA_W(DW), .COEF_W(CW), .OUT_W(OW)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #(PERIOD / 2) clk = ~clk;

   task automatic check_val(input string tag, input longint obs, input longint exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint ref_coef(input int kk, input int n);
      real ck;
      real v;
      ck = (kk == 0) ? 1.0 / $sqrt(2.0) : 1.0;
      v  = ck / 2.0 * $cos(real'((2 * n + 1) * kk) * PI / 16.0) * (2.0 ** (CW - 2));
      return (v >= 0.0) ? longint'($floor(v + 0.5)) : -longint'($floor(-v + 0.5));
   endfunction

   function automatic longint ref_y(input logic [2:0] kk, input logic [7:0][7:0] xx);
      longint s;
      s = 0;
      for (int n = 0; n < 8; n++) s += ref_coef(int'(kk), n) * longint'($signed(xx[n]));
`ifdef DA_DCT_ROUND_EN
      s = s + (64'sd1 <<< (CW - 3));
`endif
      return s >>> (CW - 2);
   endfunction

   // scoreboard: compare every result at the cycle before its handshake edge
   always @(negedge clk) begin
      if (reset && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) check_val("sb_underflow", 1, 0);
         else check_val("sb_y", longint'(bus.y), sb.pop_front());
      end
   end

   task automatic send_job(input logic [2:0] kk, input logic [7:0][7:0] xx);
      int waited;
      waited = 0;
      while (!bus.in_ready && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!bus.in_ready) check_val("in_ready_wait", 0, 1);
      else begin
         bus.k = kk;
         bus.x = xx;
         bus.start = 1'b1;
         sb.push_back(ref_y(kk, xx));
         @(posedge clk);
         accept_time = $time;
         #1;
         bus.start = 1'b0;
      end
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 1;
      while (!bus.out_valid && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check_val("drain", sb.size(), 0);
      @(posedge clk); #1;
   endtask

   function automatic logic [7:0][7:0] rand_x();
      logic [7:0][7:0] r;
      for (int n = 0; n < 8; n++) r[n] = 8'($urandom_range(0, 255));
      return r;
   endfunction

   initial begin
      logic [7:0][7:0] xv;
      longint t_a;
      longint y_hold;
      int cyc;
      int seen;
      total = 0;
      bad = 0;
      bus.x = '0;
      bus.k = 3'd0;
      bus.start = 1'b0;
      bus.out_ready = 1'b1;
      reset = 1'b1;
      #2 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_in_ready", bus.in_ready, 1);
      check_val("rst_out_valid", bus.out_valid, 0);
      check_val("rst_y", longint'(bus.y), 0);
      reset = 1'b1;
      @(posedge clk); #1;

      // k=0, all ones: latency and value
      for (int n = 0; n < 8; n++) xv[n] = 8'd1;
      send_job(3'd0, xv);
      t_a = accept_time;
      wait_valid(cyc);
      check_val("latency", cyc, 9);
      check_val("y_k0_ones", longint'(bus.y), EXP_ONES);

      // k=0, all -128, accepted on the handshake edge of the previous job
      for (int n = 0; n < 8; n++) xv[n] = 8'h80;
      send_job(3'd0, xv);
      check_val("throughput", accept_time - t_a, 9 * PERIOD);
      wait_valid(cyc);
      check_val("latency_b2b", cyc, 9);
      check_val("y_k0_neg", longint'(bus.y), EXP_NEG);

      // k=4, single impulse
      xv = '0;
      xv[0] = 8'd100;
      send_job(3'd4, xv);
      wait_valid(cyc);
      check_val("y_k4_imp", longint'(bus.y), 35);
      wait_drain();

      // stall in DONE: outputs hold, start ignored, then accept on handshake edge
      bus.out_ready = 1'b0;
      send_job(3'd5, rand_x());
      wait_valid(cyc);
      check_val("stall_latency", cyc, 9);
      y_hold = longint'(bus.y);
      for (int i = 0; i < 3; i++) begin
         bus.start = 1'b1;
         bus.x = rand_x();
         bus.k = 3'($urandom_range(0, 7));
         @(posedge clk); #1;
         check_val("stall_valid", bus.out_valid, 1);
         check_val("stall_y", longint'(bus.y), y_hold);
         check_val("stall_in_ready", bus.in_ready, 0);
      end
      xv = rand_x();
      bus.x = xv;
      bus.k = 3'd2;
      bus.out_ready = 1'b1;
      sb.push_back(ref_y(3'd2, xv));
      @(posedge clk); #1;
      bus.start = 1'b0;
      check_val("resume_in_ready", bus.in_ready, 0);
      check_val("resume_valid", bus.out_valid, 0);
      wait_valid(cyc);
      check_val("resume_latency", cyc, 9);
      wait_drain();

      // reset in the middle of a job
      send_job(3'd3, rand_x());
      repeat (3) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      void'(sb.pop_back());
      check_val("abort_in_ready", bus.in_ready, 1);
      check_val("abort_valid", bus.out_valid, 0);
      check_val("abort_y", longint'(bus.y), 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen++;
      end
      check_val("abort_no_valid", seen, 0);
      send_job(3'd6, rand_x());
      wait_drain();

      // random jobs against the reference model
      for (int i = 0; i < 1000; i++) begin
         send_job(3'($urandom_range(0, 7)), rand_x());
      end
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/da_dct_coeff.md
DA_DCT_COEFF -- requirements
Module: da_dct_coeff

Interface
REQ-001 SHALL have parameter DATA_W, default 8, sample width (signed two's complement).
REQ-002 SHALL have parameter COEF_W, default 16, coefficient width, scale 2^(COEF_W-2).
REQ-003 SHALL have parameter OUT_W, default DATA_W+3, result width; OUT_W >= DATA_W+3 is required.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port x, input, 8 x DATA_W signed, samples x[0]..x[7].
REQ-007 SHALL have port k, input, 3, DCT coefficient index to compute.
REQ-008 SHALL have ports start (input, 1) and in_ready (output, 1); a job is accepted when both are high.
REQ-009 SHALL have ports y (output, OUT_W signed), out_valid (output, 1) and out_ready (input, 1).

Function
REQ-010 SHALL compute Y = sum over n=0..7 of c[k][n]*x[n], exactly, at ACC_W = COEF_W+DATA_W+3 bits.
REQ-011 SHALL use c[k][n] = round(C(k)/2*cos((2n+1)k*pi/16)*2^(COEF_W-2)), with C(0)=1/sqrt2 and C(k>0)=1; COEF_W=16 gives c[0][n]=5793.
REQ-012 SHALL use distributed arithmetic: two 16-entry partial-sum LUTs (n=0..3 and n=4..7), each entry COEF_W+2 bits, contents selected by the latched k.
REQ-013 SHALL process one sample bit-plane per cycle, LSB first: acc += (L_lo+L_hi) << j for j < DATA_W-1, and acc -= (L_lo+L_hi) << j for j = DATA_W-1 (sign plane).
REQ-014 SHALL use states IDLE, RUN and DONE: IDLE->RUN on accept; RUN->DONE after DATA_W cycles; DONE->IDLE on out_ready, or DONE->RUN when out_ready and start coincide.
REQ-015 SHALL latch x and k on accept; input changes during RUN or DONE have no effect.
REQ-016 SHALL drive in_ready = (state==IDLE) | (state==DONE & out_ready); start with in_ready low is ignored and not queued.
REQ-017 SHALL assert out_valid exactly DATA_W+1 cycles after the accept edge, hold it in DONE, and deassert it on the handshake edge unless a new job makes it valid again later.
REQ-018 SHALL hold y stable while out_valid is high, regardless of out_ready.
REQ-019 SHALL output y = Y >>> (COEF_W-2), truncated with arithmetic floor, into OUT_W bits (no overflow possible per REQ-003).
REQ-020 SHALL give back-to-back jobs a throughput of one result per DATA_W+1 cycles.

Reset
REQ-021 SHALL, while reset is low, force state=IDLE, acc=0, bit counter=0, y=0, out_valid=0 and in_ready=1, asynchronously.
REQ-022 SHALL, on reset asserted mid-RUN or in DONE, discard the job; no out_valid is produced for it after release.

Configuration
REQ-023 SHALL, with DA_DCT_ROUND_EN defined, output y = (Y + 2^(COEF_W-3)) >>> (COEF_W-2) (round half up); without the macro, output truncation per REQ-019; latency is identical either way.

Structure
REQ-024 SHALL place in package da_dct_pkg: the N=8 constant, the coefficient function c(k,n), the LUT-entry function lut(k,half,addr), and the state enum.
REQ-025 SHALL use one sub-module, da_dct_lut (combinational partial-sum ROM, parameter COEF_W, inputs k/half/addr); it is instantiated twice.

Verification
REQ-026 SHALL cover: k=0, all x=1 -> Y=46344; y=2 (truncate) or y=3 (DA_DCT_ROUND_EN); out_valid at accept+9.
REQ-027 SHALL cover: k=0, all x=-128 -> Y=-5932032; y=-363 (truncate) or y=-362 (round).
REQ-028 SHALL cover: k=4, x=(100,0,0,0,0,0,0,0) -> y=35 in both modes; random x/k versus a reference model, 1000 jobs, zero mismatches.
REQ-029 SHALL cover: out_ready low for 3 cycles in DONE -> y and out_valid stable, in_ready=0, start ignored; then out_ready=1 with start=1 -> new job accepted on the same edge.
REQ-030 SHALL cover: reset pulled low at RUN cycle 4 -> all outputs at reset values immediately; no out_valid follows release; the next job is correct.
